// File: rtl/mem_access_unit.sv
// Load/store unit bridging a stalling pipeline stage to a req/addr_ok/data_ok data bus.
// Optional MEM_ADDR_ERR_EN: misaligned accesses trap instead of being issued with the low bits cleared.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic                mem_wr,
  input  logic [1:0]          mem_size,
  input  logic                mem_sext,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                flush,
  output logic                mem_stall,
  output logic                mem_done,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                addr_err_ld,
  output logic                addr_err_st,
  output logic [ADDR_W-1:0]   bad_vaddr,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic [1:0]          fsm_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam logic [DATA_W-1:0] ONES = '1;

  // Bus handshake: data_req with its fields is held stable until data_addr_ok is
  // seen high on a rising edge; data_data_ok then delivers read data for that request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic              wr_q, sext_q, cancel_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LANE_W-1:0] lane_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic [1:0]        size_eff;
  logic [2:0]        low_bits;
  logic [ADDR_W-1:0] addr_aligned;
  logic              addr_err, accept, live, kill, in_req;

  // A dword request on a 32-bit bus degrades to a word access.
  always_comb begin
    size_eff = mem_size;
    if (DATA_W == 32 && mem_size == 2'b11) size_eff = 2'b10;
    case (size_eff)
      2'b00:   low_bits = 3'b000;
      2'b01:   low_bits = 3'b001;
      2'b10:   low_bits = 3'b011;
      default: low_bits = 3'b111;
    endcase
    addr_aligned = mem_addr & ~{{(ADDR_W-3){1'b0}}, low_bits};
  end

  assign live = !rst;

`ifdef MEM_ADDR_ERR_EN
  logic misalign;
  assign misalign    = |(mem_addr[2:0] & low_bits);
  assign addr_err    = live && state == S_IDLE && mem_en && !flush && misalign;
  assign addr_err_ld = addr_err && !mem_wr;
  assign addr_err_st = addr_err && mem_wr;
  assign bad_vaddr   = addr_err ? mem_addr : '0;
`else
  assign addr_err    = 1'b0;
  assign addr_err_ld = 1'b0;
  assign addr_err_st = 1'b0;
  assign bad_vaddr   = '0;
`endif

  assign accept = live && state == S_IDLE && mem_en && !flush && !addr_err;
  assign kill   = cancel_q || flush;
  assign in_req = live && state == S_REQ;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_REQ;
      S_REQ:  if (data_addr_ok) state_nx = S_WAIT;
      S_WAIT: if (data_data_ok) state_nx = kill ? S_IDLE : S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Size-dependent masks and read alignment, all from the latched request.
  logic [6:0]        nbits;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] size_mask, rshift, rdata_aligned;
  logic              sign;

  always_comb begin
    case (size_q)
      2'b00:   begin nbits = 7'd8;  strb_base = 8'h01; end
      2'b01:   begin nbits = 7'd16; strb_base = 8'h03; end
      2'b10:   begin nbits = 7'd32; strb_base = 8'h0F; end
      default: begin nbits = 7'd64; strb_base = 8'hFF; end
    endcase
    size_mask = ~(ONES << nbits);
    rshift    = data_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   sign = rshift[7];
      2'b01:   sign = rshift[15];
      2'b10:   sign = rshift[31];
      default: sign = rshift[DATA_W-1];
    endcase
    rdata_aligned = (sext_q && sign) ? (rshift | ~size_mask) : (rshift & size_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      sext_q   <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      lane_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_q    <= mem_wr;
        size_q  <= size_eff;
        sext_q  <= mem_sext;
        addr_q  <= addr_aligned;
        lane_q  <= addr_aligned[LANE_W-1:0];
        wdata_q <= mem_wdata;
      end
      if (state_nx == S_IDLE)
        cancel_q <= 1'b0;
      else if ((state == S_REQ || state == S_WAIT) && flush)
        cancel_q <= 1'b1;
      if (state == S_WAIT && data_data_ok && !kill && !wr_q)
        rdata_q <= rdata_aligned;
    end
  end

  assign mem_stall  = accept || (live && (state == S_REQ || state == S_WAIT) && !kill);
  assign mem_done   = live && state == S_DONE;
  assign mem_rdata  = rdata_q;
  assign data_req   = in_req;
  assign data_wr    = in_req && wr_q;
  assign data_size  = in_req ? size_q : 2'b00;
  assign data_addr  = in_req ? addr_q : '0;
  assign data_wstrb = (in_req && wr_q) ? (strb_base[STRB_W-1:0] << lane_q) : '0;
  assign data_wdata = (in_req && wr_q) ? ((wdata_q & size_mask) << {lane_q, 3'b000}) : '0;
  assign fsm_state  = live ? state : S_IDLE;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance for most cases plus a 64-bit instance.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        en = 0, wr = 0, sext = 0, flush = 0, aok = 0, dok = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wdata = 0, rdata = 0;
  logic        stall, done, err_ld, err_st, dreq, dwr;
  logic [31:0] mrdata, bad, daddr, dwdata;
  logic [1:0]  dsize, st;
  logic [3:0]  wstrb;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .mem_en(en), .mem_wr(wr), .mem_size(size), .mem_sext(sext),
    .mem_addr(addr), .mem_wdata(wdata), .flush(flush), .mem_stall(stall), .mem_done(done),
    .mem_rdata(mrdata), .addr_err_ld(err_ld), .addr_err_st(err_st), .bad_vaddr(bad),
    .data_req(dreq), .data_wr(dwr), .data_size(dsize), .data_addr(daddr), .data_wstrb(wstrb),
    .data_wdata(dwdata), .data_addr_ok(aok), .data_data_ok(dok), .data_rdata(rdata),
    .fsm_state(st)
  );

  // 64-bit instance
  logic        en6 = 0, wr6 = 0, sext6 = 0, aok6 = 0, dok6 = 0;
  logic [1:0]  size6 = 0;
  logic [31:0] addr6 = 0;
  logic [63:0] wdata6 = 0, rdata6 = 0;
  logic        stall6, done6, err_ld6, err_st6, dreq6, dwr6;
  logic [63:0] mrdata6, dwdata6;
  logic [31:0] bad6, daddr6;
  logic [1:0]  dsize6, st6;
  logic [7:0]  wstrb6;

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .mem_en(en6), .mem_wr(wr6), .mem_size(size6), .mem_sext(sext6),
    .mem_addr(addr6), .mem_wdata(wdata6), .flush(1'b0), .mem_stall(stall6), .mem_done(done6),
    .mem_rdata(mrdata6), .addr_err_ld(err_ld6), .addr_err_st(err_st6), .bad_vaddr(bad6),
    .data_req(dreq6), .data_wr(dwr6), .data_size(dsize6), .data_addr(daddr6), .data_wstrb(wstrb6),
    .data_wdata(dwdata6), .data_addr_ok(aok6), .data_data_ok(dok6), .data_rdata(rdata6),
    .fsm_state(st6)
  );

  int total = 0;
  int bad_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic x,
                       input logic [31:0] a, input logic [31:0] d);
    en = 1; wr = w; size = s; sext = x; addr = a; wdata = d;
  endtask

  initial begin
    // reset with a request pending: every output must stay 0
    issue(0, 2'b10, 0, 32'h1000, 32'h0);
    cyc(); cyc(); settle();
    check("rst_stall", stall, 0);
    check("rst_req", dreq, 0);
    check("rst_done", done, 0);
    check("rst_rdata", mrdata, 0);
    check("rst_state", st, 0);
    check("rst_stall64", stall6, 0);

    // lb sext, 0x1003
    rst = 0;
    issue(0, 2'b00, 1, 32'h1003, 32'h0);
    settle();
    check("lb_stall_T", stall, 1);
    cyc(); en = 0; aok = 1; settle();
    check("lb_req", dreq, 1);
    check("lb_addr", daddr, 32'h1003);
    check("lb_size", dsize, 2'b00);
    check("lb_wstrb", wstrb, 4'h0);
    cyc(); aok = 0; dok = 1; rdata = 32'h80FFFF7F; settle();
    check("lb_wait_stall", stall, 1);
    check("lb_wait_req", dreq, 0);
    cyc(); dok = 0; settle();
    check("lb_done_T3", done, 1);
    check("lb_rdata", mrdata, 32'hFFFFFF80);
    check("lb_done_stall", stall, 0);
    cyc(); settle();
    check("lb_done_once", done, 0);
    check("lb_idle", st, 0);

    // sh 0x2002
    issue(1, 2'b01, 0, 32'h2002, 32'h1234ABCD);
    settle();
    check("sh_stall_T", stall, 1);
    cyc(); en = 0; aok = 1; settle();
    check("sh_wr", dwr, 1);
    check("sh_wstrb", wstrb, 4'b1100);
    check("sh_wdata", dwdata, 32'hABCD0000);
    check("sh_size", dsize, 2'b01);
    check("sh_addr", daddr, 32'h2002);
    cyc(); aok = 0; dok = 1; rdata = 32'hDEADBEEF;
    cyc(); dok = 0; settle();
    check("sh_done", done, 1);
    check("sh_rdata_kept", mrdata, 32'hFFFFFF80);
    cyc();

    // misaligned lw 0x3001
    issue(0, 2'b10, 0, 32'h3001, 32'h0);
    settle();
`ifdef MEM_ADDR_ERR_EN
    check("lw_err_ld", err_ld, 1);
    check("lw_err_st", err_st, 0);
    check("lw_bad_vaddr", bad, 32'h3001);
    check("lw_err_stall", stall, 0);
    cyc(); settle();
    check("lw_err_no_req", dreq, 0);
    check("lw_err_idle", st, 0);
    issue(1, 2'b01, 0, 32'h3003, 32'h0);
    settle();
    check("sh_err_st", err_st, 1);
    check("sh_bad_vaddr", bad, 32'h3003);
    cyc(); en = 0; settle();
    check("sh_err_no_req", dreq, 0);
`else
    check("lw_no_err", err_ld, 0);
    check("lw_bad_zero", bad, 0);
    check("lw_mis_stall", stall, 1);
    cyc(); en = 0; aok = 1; settle();
    check("lw_mis_addr", daddr, 32'h3000);
    cyc(); aok = 0; dok = 1; rdata = 32'h11223344;
    cyc(); dok = 0; settle();
    check("lw_mis_rdata", mrdata, 32'h11223344);
    cyc();
`endif

    // dword on 32-bit bus, address accept held off for 3 cycles
    issue(0, 2'b11, 0, 32'h4000, 32'h0);
    settle();
    check("ld_stall_T", stall, 1);
    cyc(); en = 0; aok = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("hold_req", dreq, 1);
      check("hold_addr", daddr, 32'h4000);
      check("hold_size", dsize, 2'b10);
      check("hold_stall", stall, 1);
      if (i == 3) aok = 1;
      cyc();
    end
    aok = 0; dok = 1; rdata = 32'hCAFEF00D; settle();
    check("hold_in_wait", st, 2);
    cyc(); dok = 0; settle();
    check("hold_done", done, 1);
    check("hold_rdata", mrdata, 32'hCAFEF00D);
    cyc();

    // flush in WAIT, data arrives a cycle later
    issue(0, 2'b10, 0, 32'h5000, 32'h0);
    cyc(); en = 0; aok = 1;
    cyc(); aok = 0; flush = 1; settle();
    check("fw_flush_stall", stall, 0);
    cyc(); flush = 0; dok = 1; rdata = 32'h55555555; settle();
    check("fw_cancel_stall", stall, 0);
    check("fw_still_wait", st, 2);
    cyc(); dok = 0; settle();
    check("fw_no_done", done, 0);
    check("fw_idle", st, 0);
    check("fw_rdata_kept", mrdata, 32'hCAFEF00D);

    // flush in IDLE blocks acceptance
    issue(0, 2'b10, 0, 32'h7000, 32'h0);
    flush = 1; settle();
    check("fi_stall", stall, 0);
    cyc(); en = 0; flush = 0; settle();
    check("fi_idle", st, 0);
    check("fi_no_req", dreq, 0);

    // flush coincident with data_data_ok
    issue(0, 2'b10, 0, 32'h6000, 32'h0);
    cyc(); en = 0; aok = 1;
    cyc(); aok = 0; flush = 1; dok = 1; rdata = 32'h66666666;
    cyc(); flush = 0; dok = 0; settle();
    check("fd_idle", st, 0);
    check("fd_no_done", done, 0);
    check("fd_rdata_kept", mrdata, 32'hCAFEF00D);

    // flush in REQ: handshake still completes, data discarded
    issue(0, 2'b00, 0, 32'h8001, 32'h0);
    cyc(); en = 0; flush = 1; settle();
    check("fr_flush_stall", stall, 0);
    check("fr_req_kept", dreq, 1);
    cyc(); flush = 0; settle();
    check("fr_still_req", st, 1);
    check("fr_cancel_stall", stall, 0);
    aok = 1;
    cyc(); aok = 0; dok = 1; rdata = 32'h77777777; settle();
    check("fr_wait_stall", stall, 0);
    cyc(); dok = 0; settle();
    check("fr_idle", st, 0);
    check("fr_no_done", done, 0);
    check("fr_rdata_kept", mrdata, 32'hCAFEF00D);

    // cancel must have cleared: normal lbu lane 1
    issue(0, 2'b00, 0, 32'h9001, 32'h0);
    cyc(); en = 0; aok = 1; settle();
    check("lbu_stall", stall, 1);
    cyc(); aok = 0; dok = 1; rdata = 32'h0000AB00;
    cyc(); dok = 0; settle();
    check("lbu_done", done, 1);
    check("lbu_rdata", mrdata, 32'h000000AB);
    cyc();

    // reset mid-transaction
    issue(0, 2'b10, 0, 32'hA000, 32'h0);
    cyc(); en = 0; rst = 1; settle();
    check("mr_req_gated", dreq, 0);
    check("mr_stall_gated", stall, 0);
    cyc(); rst = 0; settle();
    check("mr_idle", st, 0);
    check("mr_rdata_clr", mrdata, 0);
    cyc(); settle();
    check("mr_no_done", done, 0);
    check("mr_no_req", dreq, 0);

    // 64-bit: lwu at 0x0C
    en6 = 1; wr6 = 0; size6 = 2'b10; sext6 = 0; addr6 = 32'h0C; settle();
    check("w64_stall_T", stall6, 1);
    cyc(); en6 = 0; aok6 = 1; settle();
    check("w64_size", dsize6, 2'b10);
    check("w64_addr", daddr6, 32'h0C);
    check("w64_wstrb", wstrb6, 8'h00);
    cyc(); aok6 = 0; dok6 = 1; rdata6 = 64'hF000000000000000;
    cyc(); dok6 = 0; settle();
    check("w64_done", done6, 1);
    check("w64_rdata", mrdata6, 64'h00000000F0000000);
    cyc();

    // 64-bit: sb at lane 5
    en6 = 1; wr6 = 1; size6 = 2'b00; addr6 = 32'h15; wdata6 = 64'h11223344556677AB;
    cyc(); en6 = 0; aok6 = 1; settle();
    check("b64_wstrb", wstrb6, 8'h20);
    check("b64_wdata", dwdata6, 64'h0000AB0000000000);
    cyc(); aok6 = 0; dok6 = 1;
    cyc(); dok6 = 0; settle();
    check("b64_done", done6, 1);
    check("b64_rdata_kept", mrdata6, 64'h00000000F0000000);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data-bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have pipeline inputs:
- mem_en (1): memory instruction present.
- mem_wr (1): 1 = store.
- mem_size (2): 00 byte, 01 half, 10 word, 11 dword.
- mem_sext (1): sign-extend loads.
- mem_addr (ADDR_W).
- mem_wdata (DATA_W).
- flush (1): kill the current instruction.
REQ-006 SHALL have pipeline outputs:
- mem_stall (1).
- mem_done (1).
- mem_rdata (DATA_W).
- addr_err_ld (1), addr_err_st (1).
- bad_vaddr (ADDR_W).
REQ-007 SHALL have bus outputs:
- data_req (1), data_wr (1), data_size (2).
- data_addr (ADDR_W).
- data_wstrb (DATA_W/8).
- data_wdata (DATA_W).
REQ-008 SHALL have bus inputs data_addr_ok (1), data_data_ok (1) and data_rdata (DATA_W).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-010 IDLE: when mem_en, no flush and no address error, SHALL latch wr, size, sext, addr, lane and write data, then move to REQ.
REQ-011 REQ: SHALL drive data_req=1 with bus fields taken from the latched registers; on data_addr_ok SHALL move to WAIT.
REQ-012 REQ: once data_req is asserted, bus fields SHALL stay stable until data_addr_ok.
REQ-013 WAIT: on data_data_ok SHALL register the aligned read data into mem_rdata and move to DONE; mem_rdata SHALL update for loads only.
REQ-014 DONE: SHALL assert mem_done=1 for exactly one cycle, then return to IDLE unconditionally; mem_en is not sampled in DONE.
REQ-015 mem_stall SHALL be 1 when mem_en=1 in IDLE with the request accepted, and in REQ or WAIT while the access is not cancelled; otherwise mem_stall SHALL be 0.
REQ-016 Minimum latency with zero-wait bus SHALL be: accept at T, REQ at T+1, WAIT at T+2, DONE at T+3.
REQ-017 Lane SHALL be addr[log2(DATA_W/8)-1:0].
REQ-018 data_wstrb SHALL be the size mask (1, 3, F or FF) shifted left by lane, and SHALL be all zeros for loads.
REQ-019 data_wdata SHALL be mem_wdata masked to the access size, then shifted left by lane*8.
REQ-020 Read alignment SHALL shift data_rdata right by lane*8, keep size*8 bits, and fill the upper bits with the top bit of the kept field if sext=1, else with zeros.
REQ-021 When DATA_W=32, mem_size=11 SHALL be treated as a word access.
REQ-022 Flush in IDLE SHALL block acceptance.
REQ-023 Flush in REQ SHALL set a cancel flag; the handshake SHALL still complete, and WAIT SHALL then discard the data with no DONE and return to IDLE on data_data_ok.
REQ-024 Flush in WAIT SHALL set the cancel flag with the same discard behaviour as REQ-023.
REQ-025 While cancelled, mem_stall SHALL be 0.
REQ-026 data_data_ok arriving in the same cycle as flush SHALL be discarded.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the cancel flag SHALL clear.
REQ-028 During reset all outputs SHALL be 0, including mem_rdata and bad_vaddr; reset mid-transaction SHALL abandon it with no mem_done.

Configuration
REQ-029 Macro MEM_ADDR_ERR_EN defined: a misaligned half (addr[0]), word (addr[1:0]) or dword (addr[2:0]) access in IDLE SHALL NOT be issued.
REQ-030 With MEM_ADDR_ERR_EN defined, such an access SHALL assert addr_err_ld or addr_err_st (per mem_wr) combinationally for that cycle, with bad_vaddr=mem_addr and mem_stall=0.
REQ-031 Macro MEM_ADDR_ERR_EN undefined: addr_err_ld, addr_err_st and bad_vaddr SHALL be tied to 0.
REQ-032 With MEM_ADDR_ERR_EN undefined, misaligned accesses SHALL be issued with the offending low address bits forced to 0.

Verification (DATA_W=32 unless stated)
REQ-033 lb, sext=1, addr 0x1003, data_rdata 0x80FFFF7F -> mem_rdata 0xFFFFFF80, mem_done at T+3.
REQ-034 sh, addr 0x2002, wdata 0x1234ABCD -> data_wr=1, data_wstrb 1100, data_wdata 0xABCD0000, data_size 01.
REQ-035 lw, addr 0x3001 with macro -> addr_err_ld=1, bad_vaddr 0x3001, data_req never 1; without macro -> data_addr 0x3000, no error.
REQ-036 data_addr_ok held low 3 cycles -> data_req and data_addr stay constant for 4 cycles and mem_stall stays 1.
REQ-037 flush in WAIT, then data_data_ok -> no mem_done, mem_rdata unchanged, FSM back in IDLE the next cycle.
REQ-038 DATA_W=64, lwu (sext=0), addr 0x0C, data_rdata 0xF0000000_00000000 -> data_size 10, mem_rdata 0x00000000_F0000000.
